encrypt: RTL and testbench

- LWE public-key encryptor; the transmit-side counterpart of the decrypt block.
- Encrypts one plaintext of PLAINTEXT_WIDTH bits as ct = sum over i with r[i]=1 of pk_row_i, plus (m*DELTA, 0, ..., 0), all mod CIPHERTEXT_MODULUS.
- r is a BIG_N-bit subset vector from an external RNG. DELTA = CIPHERTEXT_MODULUS/PLAINTEXT_MODULUS.
- Reads the public key from a synchronous-read RAM. Streams DIMENSION+1 ciphertext entries out in the same row order that decrypt consumes.

---
 rtl/encrypt_pkg.sv | 26 ++
 rtl/encrypt_mod_q_add.sv | 15 +
 rtl/encrypt.sv | 174 +++++++++++++++++
 tb/tb_encrypt.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/encrypt_pkg.sv
// encrypt_pkg: shared LWE constants, helper constants and the FSM state type.
// Imported by encrypt, and by decrypt on the receive side, so both blocks
// agree on the default parameter set and on row ordering.
package encrypt_pkg;

  localparam int DEF_P_MOD  = 64;    // plaintext modulus p (power of two)
  localparam int DEF_P_W    = 6;     // log2(p)
  localparam int DEF_Q_MOD  = 1024;  // ciphertext modulus q (power of two, q >= p)
  localparam int DEF_CT_W   = 21;    // ciphertext entry width, > log2(q)
  localparam int DEF_DIM    = 1;     // LWE dimension; DIM+1 columns
  localparam int DEF_BIG_N  = 30;    // public-key rows
  localparam int DEF_ADDR_W = 6;     // public-key RAM address width

  localparam int DEF_LOG_Q       = $clog2(DEF_Q_MOD);
  localparam int DEF_DELTA       = DEF_Q_MOD / DEF_P_MOD;
  localparam int DEF_DELTA_SHIFT = DEF_LOG_Q - DEF_P_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    DRAIN  = 3'd2,
    ENCODE = 3'd3,
    OUT    = 3'd4
  } state_t;

endpackage

// File: rtl/encrypt_mod_q_add.sv
// mod_q_add: modular adder for a power-of-two modulus q = 2^LOG_Q.
// Reduction is free: the carry out of bit LOG_Q-1 is simply dropped.
//   a, b : operands, already reduced to LOG_Q bits
//   sum  : (a + b) mod q
module mod_q_add #(
  parameter int LOG_Q = 10
) (
  input  logic [LOG_Q-1:0] a,
  input  logic [LOG_Q-1:0] b,
  output logic [LOG_Q-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/encrypt.sv
// encrypt: LWE public-key encryptor.
//   ct = sum_{i : r[i]=1} pk_row_i + (m*DELTA, 0, ..., 0)  (mod q)
// The public key is streamed from a synchronous-read RAM, one entry per cycle
// in row-major order; the DIMENSION+1 ciphertext entries are then presented
// on a valid/ready interface in the order decrypt consumes them.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               begin encryption (sampled only in IDLE)
//   message, subset     plaintext m and subset vector r, latched on start
//   pk_addr, pk_rd_en   RAM read request; pk_entry returns one cycle later
//   busy                high in every state except IDLE
//   ct_valid, ct_ready  ciphertext handshake; ct_entry/row hold while stalled
//   ct_entry, row       ciphertext entry (in [0,q)) and its column index
//   done                one-cycle pulse after the last entry is accepted
module encrypt
  import encrypt_pkg::*;
#(
  parameter int PLAINTEXT_MODULUS  = DEF_P_MOD,
  parameter int PLAINTEXT_WIDTH    = DEF_P_W,
  parameter int CIPHERTEXT_MODULUS = DEF_Q_MOD,
  parameter int CIPHERTEXT_WIDTH   = DEF_CT_W,
  parameter int DIMENSION          = DEF_DIM,
  parameter int BIG_N              = DEF_BIG_N,
  parameter int ADDR_WIDTH         = DEF_ADDR_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [PLAINTEXT_WIDTH-1:0]  message,
  input  logic [BIG_N-1:0]            subset,
  output logic [ADDR_WIDTH-1:0]       pk_addr,
  output logic                        pk_rd_en,
  input  logic [CIPHERTEXT_WIDTH-1:0] pk_entry,
  output logic                        busy,
  output logic                        ct_valid,
  input  logic                        ct_ready,
  output logic [CIPHERTEXT_WIDTH-1:0] ct_entry,
  output logic [DIMENSION:0]          row,
  output logic                        done
);

  localparam int LOG_Q = $clog2(CIPHERTEXT_MODULUS);
  localparam int SHIFT = LOG_Q - $clog2(PLAINTEXT_MODULUS);
  localparam int NCOL  = DIMENSION + 1;
  localparam int ROW_W = DIMENSION + 1;
  localparam int IW    = (BIG_N > 1) ? $clog2(BIG_N) : 1;

  state_t                          state;
  logic [PLAINTEXT_WIDTH-1:0]      msg_q;
  logic [BIG_N-1:0]                sub_q;
  logic [NCOL-1:0][LOG_Q-1:0]      acc;
  logic [NCOL-1:0][LOG_Q-1:0]      sum;
  logic [IW-1:0]                   ld_i, rsp_i;
  logic [ROW_W-1:0]                ld_j, rsp_j;
  logic                            rsp_vld;
  logic [LOG_Q-1:0]                delta_m, add_b;
  logic                            acc_hit;
  logic                            unused_pk_hi;

  // Only the low log2(q) bits of a key entry matter mod q.
  assign unused_pk_hi = ^pk_entry[CIPHERTEXT_WIDTH-1:LOG_Q];

  // m*DELTA as a shift; with p,q powers of two this never overflows q.
  assign delta_m = LOG_Q'(msg_q) << SHIFT;

  // All column adders share one operand: the RAM word while loading, the
  // encoded message during ENCODE (only column 0 is written then).
  assign add_b   = (state == ENCODE) ? delta_m : pk_entry[LOG_Q-1:0];

  // rsp_i/rsp_j track the key coordinates of the word now on pk_entry.
  assign acc_hit = rsp_vld && sub_q[rsp_i];

  for (genvar j = 0; j < NCOL; j++) begin : g_col
    mod_q_add #(.LOG_Q(LOG_Q)) u_add (
      .a   (acc[j]),
      .b   (add_b),
      .sum (sum[j])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      msg_q    <= '0;
      sub_q    <= '0;
      acc      <= '0;
      ld_i     <= '0;
      ld_j     <= '0;
      rsp_i    <= '0;
      rsp_j    <= '0;
      rsp_vld  <= 1'b0;
      pk_addr  <= '0;
      pk_rd_en <= 1'b0;
      busy     <= 1'b0;
      ct_valid <= 1'b0;
      ct_entry <= '0;
      row      <= '0;
      done     <= 1'b0;
    end else begin
      done    <= 1'b0;
      // Response pipeline: data for the address issued now returns next cycle.
      rsp_vld <= pk_rd_en;
      rsp_i   <= ld_i;
      rsp_j   <= ld_j;

      for (int j = 0; j < NCOL; j++)
        if (acc_hit && rsp_j == ROW_W'(j)) acc[j] <= sum[j];

      case (state)
        IDLE: begin
          if (start) begin
            msg_q    <= message;
            sub_q    <= subset;
            acc      <= '0;
            ld_i     <= '0;
            ld_j     <= '0;
            pk_addr  <= '0;
            pk_rd_en <= 1'b1;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end

        LOAD: begin
          if (ld_i == IW'(BIG_N - 1) && ld_j == ROW_W'(DIMENSION)) begin
            pk_rd_en <= 1'b0;
            pk_addr  <= '0;
            state    <= DRAIN;
          end else begin
            pk_addr <= pk_addr + 1'b1;
            if (ld_j == ROW_W'(DIMENSION)) begin
              ld_j <= '0;
              ld_i <= ld_i + 1'b1;
            end else begin
              ld_j <= ld_j + 1'b1;
            end
          end
        end

        // Last RAM response is accumulated during this cycle.
        DRAIN: state <= ENCODE;

        ENCODE: begin
          acc[0]   <= sum[0];
          ct_entry <= CIPHERTEXT_WIDTH'(sum[0]);
          row      <= '0;
          ct_valid <= 1'b1;
          state    <= OUT;
        end

        OUT: begin
          if (ct_ready) begin
            if (row == ROW_W'(DIMENSION)) begin
              ct_valid <= 1'b0;
              ct_entry <= '0;
              row      <= '0;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              row <= row + 1'b1;
              for (int j = 0; j < NCOL; j++)
                if (row + 1'b1 == ROW_W'(j))
                  ct_entry <= CIPHERTEXT_WIDTH'(acc[j]);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encrypt.sv
// tb_encrypt: self-checking bench for encrypt with a synchronous-read RAM
// model and a plain-arithmetic reference for the LWE sum.
module tb_encrypt;

  localparam int P  = 64;
  localparam int Q  = 1024;
  localparam int BN = 30;
  localparam int NC = 2;
  localparam int EXP_LAT = BN * NC + 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  message;
  logic [29:0] subset;
  logic [5:0]  pk_addr;
  logic        pk_rd_en;
  logic [20:0] pk_entry;
  logic        busy, ct_valid, ct_ready, done;
  logic [20:0] ct_entry;
  logic [1:0]  row;

  logic [20:0] ram [64];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (pk_rd_en) pk_entry <= ram[pk_addr];

  encrypt dut (
    .clk(clk), .rst_n(rst_n), .start(start), .message(message), .subset(subset),
    .pk_addr(pk_addr), .pk_rd_en(pk_rd_en), .pk_entry(pk_entry), .busy(busy),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_entry(ct_entry), .row(row),
    .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ct = sum of selected rows + (m*q/p, 0), everything mod q
  task automatic ref_ct(input int m, input logic [29:0] r, output int c0, output int c1);
    c0 = m * (Q / P);
    c1 = 0;
    for (int i = 0; i < BN; i++)
      if (r[i]) begin
        c0 += int'(ram[2*i]) % Q;
        c1 += int'(ram[2*i+1]) % Q;
      end
    c0 = c0 % Q;
    c1 = c1 % Q;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"},     32'(busy),     0);
    chk({tag, ".ct_valid"}, 32'(ct_valid), 0);
    chk({tag, ".done"},     32'(done),     0);
    chk({tag, ".rd_en"},    32'(pk_rd_en), 0);
    chk({tag, ".addr"},     32'(pk_addr),  0);
    chk({tag, ".entry"},    32'(ct_entry), 0);
    chk({tag, ".row"},      32'(row),      0);
  endtask

  // Called at #1 after the edge that accepted start. mode: 0 always ready,
  // 1 hold ready low 3 cycles on entry 0, 2 random ready.
  task automatic collect(input string tag, input int mode, input bit held,
                         output int g0, output int g1);
    int lat = 1, cyc = 0, got = 0, stalls = 0;
    bit stalled = 0, rdy;
    logic [20:0] snap_e;
    logic [1:0]  snap_r;
    g0 = -1; g1 = -1;
    chk({tag, ".busy_on"}, 32'(busy), 1);
    while (!ct_valid && lat < 200) begin
      if (!held) begin message = 6'($urandom); subset = 30'($urandom); end
      @(posedge clk); #1; lat++;
    end
    chk({tag, ".latency"}, lat, EXP_LAT);
    while (got < NC && cyc < 100) begin
      if (ct_valid) begin
        case (mode)
          1:       rdy = !(got == 0 && stalls < 3);
          2:       rdy = 1'($urandom_range(0, 1));
          default: rdy = 1'b1;
        endcase
        ct_ready = rdy;
        if (rdy) begin
          chk({tag, ".row"}, 32'(row), got);
          if (got == 0) g0 = int'(ct_entry); else g1 = int'(ct_entry);
          got++;
        end else begin
          stalls++;
          stalled = 1;
          snap_e = ct_entry;
          snap_r = row;
        end
      end
      @(posedge clk); #1; cyc++;
      ct_ready = 1'b0;
      if (stalled) begin
        chk({tag, ".hold_valid"}, 32'(ct_valid), 1);
        chk({tag, ".hold_entry"}, 32'(ct_entry), 32'(snap_e));
        chk({tag, ".hold_row"},   32'(row),      32'(snap_r));
        stalled = 0;
      end
    end
    chk({tag, ".delivered"}, got, NC);
    chk({tag, ".done"},      32'(done),     1);
    chk({tag, ".valid_off"}, 32'(ct_valid), 0);
    chk({tag, ".busy_off"},  32'(busy),     0);
  endtask

  task automatic run(input string tag, input int m, input logic [29:0] r,
                     input int mode, output int g0, output int g1);
    message = 6'(m);
    subset  = r;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    collect(tag, mode, 1'b0, g0, g1);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, 32'(done), 0);
  endtask

  task automatic run_chk(input string tag, input int m, input logic [29:0] r, input int mode);
    int g0, g1, e0, e1;
    ref_ct(m, r, e0, e1);
    run(tag, m, r, mode, g0, g1);
    chk({tag, ".ct0"}, g0, e0);
    chk({tag, ".ct1"}, g1, e1);
  endtask

  initial begin
    int g0, g1, e0, e1;
    rst_n = 1'b0; start = 1'b0; ct_ready = 1'b0; message = '0; subset = '0;
    for (int a = 0; a < 64; a++) ram[a] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // zero key: ct = (5*16, 0)
    run("zero_key", 5, '1, 0, g0, g1);
    chk("zero_key.ct0", g0, 80);
    chk("zero_key.ct1", g1, 0);

    // rows (i, 2i), r = rows 0 and 2
    for (int i = 0; i < BN; i++) begin ram[2*i] = 21'(i); ram[2*i+1] = 21'(2*i); end
    run("rows_101", 0, 30'b101, 0, g0, g1);
    chk("rows_101.ct0", g0, 2);
    chk("rows_101.ct1", g1, 4);

    // wrap-around
    for (int i = 0; i < BN; i++) begin ram[2*i] = 21'd1000; ram[2*i+1] = 21'd1023; end
    run("wrap", 1, 30'b11, 0, g0, g1);
    chk("wrap.ct0", g0, 992);
    chk("wrap.ct1", g1, 1022);

    // backpressure on entry 0, random key with junk above bit 9
    for (int a = 0; a < 64; a++) ram[a] = 21'($urandom);
    run_chk("stall", int'($urandom_range(0, 63)), 30'($urandom), 1);

    // reset during LOAD, then a clean run
    message = 6'd9; subset = '1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_idle("mid_reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_idle("post_reset");
    run_chk("after_reset", 9, 30'($urandom), 0);

    // round trip with secret s = 3: pk row i = (-3*a_i, a_i), a_i = i
    for (int i = 0; i < BN; i++) begin
      ram[2*i]   = 21'(((Q - (3*i) % Q)) % Q);
      ram[2*i+1] = 21'(i);
    end
    run("round_trip", 38, '1, 0, g0, g1);
    chk("round_trip.phase", (g0 + 3*g1) % Q, 608);
    chk("round_trip.decode", (((g0 + 3*g1) % Q + (Q/P)/2) / (Q/P)) % P, 38);

    // start held high: re-encrypts right after the done cycle
    for (int a = 0; a < 64; a++) ram[a] = 21'($urandom);
    message = 6'd17; subset = 30'($urandom);
    ref_ct(17, subset, e0, e1);
    start = 1'b1;
    @(posedge clk); #1;
    collect("held1", 0, 1'b1, g0, g1);
    chk("held1.ct0", g0, e0);
    chk("held1.ct1", g1, e1);
    @(posedge clk); #1;
    start = 1'b0;
    collect("held2", 2, 1'b0, g0, g1);
    chk("held2.ct0", g0, e0);
    chk("held2.ct1", g1, e1);
    @(posedge clk); #1;
    chk("held2.done_pulse", 32'(done), 0);

    // random keys, messages, subsets and ready patterns
    for (int t = 0; t < 6; t++) begin
      for (int a = 0; a < 64; a++) ram[a] = 21'($urandom);
      run_chk($sformatf("rand%0d", t), int'($urandom_range(0, 63)), 30'($urandom), 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
